alu_accum_sequencer: RTL and testbench
======================================

Name: alu_accum_sequencer

Overview:
- Upstream command/accumulator stage that feeds the 5-bit likeALU operand/select inputs and consumes its combinational result.
- Accepts one command at a time over a valid/ready handshake and drives registered A/B/select to the ALU for one execute cycle.
- Captures the ALU result into an accumulator and presents it on a valid/ready result port.
- Keeps a wrap-around count of completed operations.

Parameters:
- W, 5, datapath width; matches the likeALU inp_A, inp_B and out widths.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_load  in  1  1 = load cmd_operand directly into the accumulator (ALU bypass); 0 = ALU operation.
- cmd_sel  in  2  ALU select code; passed through opaquely.
- cmd_operand  in  W  B operand, or load value.
- alu_a  out  W  to likeALU inp_A; registered.
- alu_b  out  W  to likeALU inp_B; registered.
- alu_sel  out  2  to likeALU select; registered.
- alu_out  in  W  from likeALU out; combinational result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  W  result value; equals the accumulator after the operation.
- acc  out  W  current accumulator value.
- op_count  out  CNT_W  completed commands (results handed off); wraps.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state = IDLE; acc = 0; alu_a = alu_b = 0; alu_sel = 0; res_data = 0; res_valid = 0; op_count = 0.
  - cmd_ready = 0; it is driven by a ready flop that reset clears and that sets on the first clk edge after rst_n rises.
- States: IDLE, EXEC, RESP. The encoding is implementation choice.
- IDLE:
  - cmd_ready = 1 (after the post-reset cycle).
  - On cmd_valid && cmd_ready at edge N:
    - cmd_load = 0: alu_a <= acc, alu_b <= cmd_operand, alu_sel <= cmd_sel; go to EXEC.
    - cmd_load = 1: acc <= cmd_operand, res_data <= cmd_operand, res_valid <= 1; go directly to RESP. alu_* hold their previous values.
- EXEC:
  - cmd_ready = 0; alu_* are stable for the whole cycle.
  - At edge N+1: acc <= alu_out, res_data <= alu_out, res_valid <= 1; go to RESP.
- RESP:
  - cmd_ready = 0; res_valid = 1; res_data is held stable until the handshake.
  - On res_valid && res_ready: res_valid <= 0, op_count <= op_count + 1 (mod 2^CNT_W, 255 -> 0); go to IDLE.
- Latency:
  - ALU op: accept at edge N, res_valid high after edge N+1, earliest return to IDLE at edge N+2.
  - Load: res_valid high after edge N.
  - Throughput: at most one command per 3 cycles (ALU op) or 2 cycles (load).
- cmd_ready is low in EXEC and RESP; cmd_valid there is ignored and the command is not consumed. No command queueing.
- res_ready held high before res_valid has no effect. res_ready low stalls indefinitely in RESP with every output frozen.
- Arithmetic: the block performs none. The result is exactly alu_out, W bits; no carry or overflow is tracked.
- Select codes are not decoded by this block.
- Reset asserted mid-operation (EXEC or RESP) aborts the operation: the result is lost, op_count is not incremented, and all outputs return to their reset values immediately.
- alu_out is sampled only at the EXEC edge; changes on alu_out in other states have no effect.

Test Plan:
Bench stub ALU: sel 00 = A+B mod 32, 01 = A&B, 10 = A|B, 11 = A^B.
1. Reset/ready: assert rst_n=0 for 2 cycles, release -> all outputs 0, cmd_ready=0 for 1 edge then 1, op_count=0.
2. Load then op: load 5'b10101, res_ready=1 -> res_data=10101, acc=10101. Then sel=01 with operand 11111 -> alu_a=10101, alu_b=11111 during EXEC, res_data=10101, op_count=2.
3. Wrap add: load 11111, then sel=00 with operand 11111 -> res_data=11110 (mod 32). Then sel=11 with operand 11110 -> res_data=00000, acc=0.
4. Backpressure: ALU op with res_ready=0 for 5 cycles -> res_valid stays 1, res_data constant, cmd_ready=0. A cmd_valid pulse during the stall is not accepted. op_count increments only on the cycle res_ready=1.
5. Reset mid-EXEC: issue sel=10 with operand 00011, drop rst_n during EXEC -> acc=0, res_valid=0, op_count unchanged (0), state IDLE after release.
6. Counter wrap: 256 back-to-back loads with res_ready=1 -> op_count goes 255 -> 0; spacing between accepts is 2 cycles.

Source files
------------

// File: rtl/alu_accum_sequencer.sv
// Command/accumulator sequencer in front of a combinational likeALU.
// It accepts one command, drives registered ALU operands for one cycle, then holds the result for handoff.
module alu_accum_sequencer #(
    parameter int W     = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_sel,
    input  logic [W-1:0]     cmd_operand,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_sel,
    input  logic [W-1:0]     alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic [W-1:0]     acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;

    // cmd_ready is a flop so it stays low for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            acc       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= 2'b00;
            res_data  <= '0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_load) begin
                            acc       <= cmd_operand;
                            res_data  <= cmd_operand;
                            res_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a   <= acc;
                            alu_b   <= cmd_operand;
                            alu_sel <= cmd_sel;
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc       <= alu_out;
                    res_data  <= alu_out;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_ONE;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b0;
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_accum_sequencer.sv
// Self-checking bench: stub ALU, transaction-level reference model, directed plus random stimulus.
module tb_alu_accum_sequencer;

    localparam int W     = 5;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [1:0]       cmd_sel;
    logic [W-1:0]     cmd_operand;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [1:0]       alu_sel;
    logic [W-1:0]     alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    alu_accum_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_sel(cmd_sel), .cmd_operand(cmd_operand),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .acc(acc), .op_count(op_count)
    );

    // Stub likeALU
    always_comb begin
        case (alu_sel)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a & alu_b;
            2'b10:   alu_out = alu_a | alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: what has been accepted and what result is owed to the consumer.
    int m_acc, m_res, m_a, m_b, m_sel, m_cnt;
    bit m_primed, m_in_alu, m_have_res, m_accepted;
    int accept_cyc[$];

    function automatic int alu_ref(int a, int b, int sel);
        case (sel)
            0:       return (a + b) % 32;
            1:       return a & b;
            2:       return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic model_reset();
        m_acc = 0; m_res = 0; m_a = 0; m_b = 0; m_sel = 0; m_cnt = 0;
        m_primed = 0; m_in_alu = 0; m_have_res = 0; m_accepted = 0;
    endtask

    task automatic model_edge();
        m_accepted = 0;
        if (!rst_n) return;
        if (m_have_res) begin
            if (res_ready) begin
                m_have_res = 0;
                m_cnt = (m_cnt + 1) % 256;
            end
        end else if (m_in_alu) begin
            m_acc = alu_ref(m_a, m_b, m_sel);
            m_res = m_acc;
            m_in_alu = 0;
            m_have_res = 1;
        end else if (m_primed && cmd_valid) begin
            m_accepted = 1;
            accept_cyc.push_back(cyc);
            if (cmd_load) begin
                m_acc = int'(cmd_operand);
                m_res = m_acc;
                m_have_res = 1;
            end else begin
                m_a = m_acc;
                m_b = int'(cmd_operand);
                m_sel = int'(cmd_sel);
                m_in_alu = 1;
            end
        end
        m_primed = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        chk("cmd_ready", 32'(cmd_ready), (m_primed && !m_in_alu && !m_have_res) ? 32'd1 : 32'd0);
        chk("res_valid", 32'(res_valid), 32'(m_have_res));
        chk("res_data",  32'(res_data),  m_res);
        chk("acc",       32'(acc),       m_acc);
        chk("alu_a",     32'(alu_a),     m_a);
        chk("alu_b",     32'(alu_b),     m_b);
        chk("alu_sel",   32'(alu_sel),   m_sel);
        chk("op_count",  32'(op_count),  m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue(input bit load, input logic [1:0] sel, input logic [W-1:0] op);
        int n;
        cmd_valid = 1'b1; cmd_load = load; cmd_sel = sel; cmd_operand = op;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_accepted && n < 20);
        chk("accept_timeout", 32'(m_accepted), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_sel = 2'b00;
        cmd_operand = '0; res_ready = 1'b0;
        model_reset();

        // 1: reset and ready release
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        #1 chk("rel_cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
        tick();
        chk("rel_cmd_ready_after_edge", 32'(cmd_ready), 32'd1);

        // 2: load then AND
        res_ready = 1'b1;
        issue(1'b1, 2'b00, 5'b10101);
        chk("load_res_data", 32'(res_data), 32'd21);
        chk("load_acc", 32'(acc), 32'd21);
        chk("load_res_valid", 32'(res_valid), 32'd1);
        wait_idle();
        chk("load_op_count", 32'(op_count), 32'd1);
        issue(1'b0, 2'b01, 5'b11111);
        chk("exec_alu_a", 32'(alu_a), 32'd21);
        chk("exec_alu_b", 32'(alu_b), 32'd31);
        chk("exec_res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("and_res_data", 32'(res_data), 32'd21);
        wait_idle();
        chk("and_op_count", 32'(op_count), 32'd2);

        // 3: wrap add then xor to zero
        issue(1'b1, 2'b00, 5'b11111);
        wait_idle();
        issue(1'b0, 2'b00, 5'b11111);
        tick();
        chk("add_wrap_res", 32'(res_data), 32'd30);
        wait_idle();
        issue(1'b0, 2'b11, 5'b11110);
        tick();
        chk("xor_res", 32'(res_data), 32'd0);
        chk("xor_acc", 32'(acc), 32'd0);
        wait_idle();

        // 4: backpressure, acc 0 + 1
        res_ready = 1'b0;
        issue(1'b0, 2'b00, 5'd1);
        tick();
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 5'd7;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_data", 32'(res_data), 32'd1);
            chk("bp_hold_ready", 32'(cmd_ready), 32'd0);
            chk("bp_hold_count", 32'(op_count), 32'd5);
        end
        chk("bp_acc_kept", 32'(acc), 32'd1);
        res_ready = 1'b1;
        tick();
        chk("bp_release_count", 32'(op_count), 32'd6);
        chk("bp_release_ready", 32'(cmd_ready), 32'd1);

        // 5: reset during EXEC
        issue(1'b0, 2'b10, 5'b00011);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_acc", 32'(acc), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_op_count", 32'(op_count), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("abort_alu_b", 32'(alu_b), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("abort_idle_ready", 32'(cmd_ready), 32'd1);
        chk("abort_idle_valid", 32'(res_valid), 32'd0);

        // 6: 256 back-to-back loads
        accept_cyc.delete();
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 5'($urandom);
        for (int g = 0; g < 1000 && accept_cyc.size() < 256; g++) begin
            tick();
            if (m_accepted) cmd_operand = 5'($urandom);
        end
        chk("wrap_accepts", 32'(accept_cyc.size()), 32'd256);
        chk("wrap_count_255", 32'(op_count), 32'd255);
        cmd_valid = 1'b0;
        tick();
        chk("wrap_count_0", 32'(op_count), 32'd0);
        for (int i = 1; i < accept_cyc.size(); i++)
            chk("load_spacing", 32'(accept_cyc[i] - accept_cyc[i-1]), 32'd2);

        // 7: random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            cmd_valid   = 1'($urandom);
            cmd_load    = ($urandom_range(0, 3) == 0);
            cmd_sel     = 2'($urandom);
            cmd_operand = 5'($urandom);
            res_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
